// File: rtl/bpred_btb_pkg.sv
// bpred_btb_pkg: shared widths and direction-counter encodings for the branch target buffer
package bpred_btb_pkg;
  localparam int DEF_DBITS = 32;
  localparam int DEF_INSTSIZE = 4;
  function automatic logic [31:0] weak_taken(int ctrbits);
    return 32'd1 << (ctrbits - 1);
  endfunction
  function automatic logic [31:0] weak_not_taken(int ctrbits);
    return (32'd1 << (ctrbits - 1)) - 32'd1;
  endfunction
endpackage

// File: rtl/bpred_btb_sat_counter.sv
// sat_counter: loadable up/down counter that saturates at zero and all-ones
//   clk, rst (async, loads RST), load/load_val (priority), inc/dec (ignored when both set), q
module sat_counter #(
  parameter int W = 2,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= RST;
    else if (load) q <= load_val;
    else if (inc && !dec && q != '1) q <= q + 1'b1;
    else if (dec && !inc && q != '0) q <= q - 1'b1;
endmodule

// File: rtl/bpred_btb.sv
// bpred_btb: direct-mapped branch target buffer with per-entry direction counters and stats
//   pc_FE -> hit_FE/predtaken_FE/pcpred_FE (combinational lookup)
//   upd_*_EX -> training at posedge, mispred_EX (combinational), stat_ctrl/stat_mispred
//   flush invalidates all entries; reset is asynchronous
module bpred_btb
  import bpred_btb_pkg::*;
#(
  parameter int DBITS = DEF_DBITS,
  parameter int INDEXBITS = 6,
  parameter int CTRBITS = 2,
  parameter int STATBITS = 16,
  parameter int INSTSIZE = DEF_INSTSIZE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [DBITS-1:0]    pc_FE,
  output logic                hit_FE,
  output logic                predtaken_FE,
  output logic [DBITS-1:0]    pcpred_FE,
  input  logic                upd_valid_EX,
  input  logic [DBITS-1:0]    upd_pc_EX,
  input  logic                upd_taken_EX,
  input  logic [DBITS-1:0]    upd_target_EX,
  input  logic                upd_predtaken_EX,
  input  logic [DBITS-1:0]    upd_predpc_EX,
  output logic                mispred_EX,
  output logic [STATBITS-1:0] stat_ctrl,
  output logic [STATBITS-1:0] stat_mispred
);
  localparam int N = 1 << INDEXBITS;
  localparam int TW = DBITS - INDEXBITS - 2;
  localparam logic [CTRBITS-1:0] WT = CTRBITS'(weak_taken(CTRBITS));
  localparam logic [CTRBITS-1:0] WNT = CTRBITS'(weak_not_taken(CTRBITS));
  logic [INDEXBITS-1:0] idx_f, idx_u;
  logic [TW-1:0] tag_f, tag_u;
  logic [N-1:0] valid;
  logic [TW-1:0] tags [N];
  logic [DBITS-1:0] tgts [N];
  logic [N-1:0][CTRBITS-1:0] ctr;
  logic [DBITS-1:0] correct;
  logic hit_u, wr, alloc;
  assign idx_f = pc_FE[INDEXBITS+1:2];
  assign tag_f = pc_FE[DBITS-1:INDEXBITS+2];
  assign idx_u = upd_pc_EX[INDEXBITS+1:2];
  assign tag_u = upd_pc_EX[DBITS-1:INDEXBITS+2];
  assign hit_FE = valid[idx_f] && tags[idx_f] == tag_f;
  assign predtaken_FE = hit_FE && ctr[idx_f][CTRBITS-1];
  assign pcpred_FE = predtaken_FE ? tgts[idx_f] : pc_FE + DBITS'(INSTSIZE);
  assign correct = upd_taken_EX ? upd_target_EX : upd_pc_EX + DBITS'(INSTSIZE);
  assign mispred_EX = upd_valid_EX && upd_predpc_EX != correct;
  assign hit_u = valid[idx_u] && tags[idx_u] == tag_u;
  assign wr = upd_valid_EX && !flush;
  assign alloc = wr && !hit_u && upd_taken_EX;
  always_ff @(posedge clk or posedge reset)
    if (reset) valid <= '0;
    else if (flush) valid <= '0;
    else if (alloc) valid[idx_u] <= 1'b1;
  // on a taken hit the tag rewrite is a no-op, so hit and allocate share one write
  always_ff @(posedge clk)
    if (wr && upd_taken_EX) begin
      tgts[idx_u] <= upd_target_EX;
      tags[idx_u] <= tag_u;
    end
  for (genvar i = 0; i < N; i++) begin : g_ctr
    logic sel;
    assign sel = wr && idx_u == INDEXBITS'(i);
    sat_counter #(.W(CTRBITS), .RST(WNT)) u_ctr (
      .clk(clk), .rst(reset), .load(sel && alloc), .load_val(WT),
      .inc(sel && hit_u && upd_taken_EX), .dec(sel && hit_u && !upd_taken_EX), .q(ctr[i])
    );
  end
  sat_counter #(.W(STATBITS)) u_stat_ctrl (
    .clk(clk), .rst(reset), .load(1'b0), .load_val('0),
    .inc(upd_valid_EX), .dec(1'b0), .q(stat_ctrl)
  );
  sat_counter #(.W(STATBITS)) u_stat_mispred (
    .clk(clk), .rst(reset), .load(1'b0), .load_val('0),
    .inc(mispred_EX), .dec(1'b0), .q(stat_mispred)
  );
endmodule

// File: tb/tb_bpred_btb.sv
// tb_bpred_btb: scoreboard bench for bpred_btb (STATBITS=3 so saturation is reachable)
module tb_bpred_btb;
  logic clk = 0, reset = 1, flush = 0;
  logic [31:0] pc_FE = 0, upd_pc_EX = 0, upd_target_EX = 0, upd_predpc_EX = 0;
  logic upd_valid_EX = 0, upd_taken_EX = 0, upd_predtaken_EX = 0;
  logic hit_FE, predtaken_FE, mispred_EX;
  logic [31:0] pcpred_FE;
  logic [2:0] stat_ctrl, stat_mispred;
  int errors = 0, checks = 0;
  typedef struct {
    logic [31:0] pc;
    logic uv;
    logic [31:0] upc;
    logic ut;
    logic [31:0] tgt;
    logic upt;
    logic [31:0] uppc;
    logic fl;
    logic [40:0] e;
  } step_t;
  logic [40:0] sb[$];
  always #5 clk = ~clk;
  bpred_btb #(.STATBITS(3)) dut (
    .clk(clk), .reset(reset), .flush(flush), .pc_FE(pc_FE), .hit_FE(hit_FE),
    .predtaken_FE(predtaken_FE), .pcpred_FE(pcpred_FE), .upd_valid_EX(upd_valid_EX),
    .upd_pc_EX(upd_pc_EX), .upd_taken_EX(upd_taken_EX), .upd_target_EX(upd_target_EX),
    .upd_predtaken_EX(upd_predtaken_EX), .upd_predpc_EX(upd_predpc_EX), .mispred_EX(mispred_EX),
    .stat_ctrl(stat_ctrl), .stat_mispred(stat_mispred)
  );
  function automatic logic [40:0] ex(logic h, logic p, logic [31:0] pp, logic m, logic [2:0] c, logic [2:0] s);
    return {h, p, pp, m, c, s};
  endfunction
  function automatic logic [40:0] obs();
    return {hit_FE, predtaken_FE, pcpred_FE, mispred_EX, stat_ctrl, stat_mispred};
  endfunction
  function automatic step_t mk(logic [31:0] pc, logic uv, logic [31:0] upc, logic ut, logic [31:0] tgt,
                               logic upt, logic [31:0] uppc, logic fl, logic [40:0] e);
    step_t s;
    s.pc = pc; s.uv = uv; s.upc = upc; s.ut = ut; s.tgt = tgt;
    s.upt = upt; s.uppc = uppc; s.fl = fl; s.e = e;
    return s;
  endfunction
  task automatic apply(step_t s);
    pc_FE = s.pc; upd_valid_EX = s.uv; upd_pc_EX = s.upc; upd_taken_EX = s.ut;
    upd_target_EX = s.tgt; upd_predtaken_EX = s.upt; upd_predpc_EX = s.uppc; flush = s.fl;
  endtask
  task automatic do_reset();
    upd_valid_EX = 0; flush = 0; reset = 1;
    @(posedge clk); #1;
    reset = 0;
  endtask
  task automatic test_reset();
    logic [40:0] e;
    reset = 1; pc_FE = 32'h100;
    sb.push_back(ex(0, 0, 32'h104, 0, 0, 0));
    #2;
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_held got=%h exp=%h", obs(), e); end
    @(posedge clk); #1;
    reset = 0;
    sb.push_back(ex(0, 0, 32'h104, 0, 0, 0));
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_release got=%h exp=%h", obs(), e); end
    @(posedge clk); #1;
  endtask
  task automatic test_counter();
    step_t s[$];
    logic [40:0] e;
    s.push_back(mk(32'h120, 1, 32'h120, 1, 32'h200, 0, 32'h124, 0, ex(0, 0, 32'h124, 1, 0, 0)));
    s.push_back(mk(32'h120, 0, 0, 0, 0, 0, 0, 0, ex(1, 1, 32'h200, 0, 1, 1)));
    s.push_back(mk(32'h120, 1, 32'h120, 0, 32'h200, 1, 32'h200, 0, ex(1, 1, 32'h200, 1, 1, 1)));
    s.push_back(mk(32'h120, 1, 32'h120, 0, 32'h200, 0, 32'h124, 0, ex(1, 0, 32'h124, 0, 2, 2)));
    s.push_back(mk(32'h120, 1, 32'h120, 1, 32'h200, 0, 32'h124, 0, ex(1, 0, 32'h124, 1, 3, 2)));
    s.push_back(mk(32'h120, 1, 32'h120, 1, 32'h200, 0, 32'h124, 0, ex(1, 0, 32'h124, 1, 4, 3)));
    s.push_back(mk(32'h120, 1, 32'h120, 1, 32'h200, 1, 32'h200, 0, ex(1, 1, 32'h200, 0, 5, 4)));
    s.push_back(mk(32'h120, 1, 32'h120, 1, 32'h200, 1, 32'h200, 0, ex(1, 1, 32'h200, 0, 6, 4)));
    s.push_back(mk(32'h120, 1, 32'h120, 0, 32'h200, 1, 32'h124, 0, ex(1, 1, 32'h200, 0, 7, 4)));
    s.push_back(mk(32'h120, 0, 0, 0, 0, 0, 0, 0, ex(1, 1, 32'h200, 0, 7, 4)));
    foreach (s[i]) begin
      apply(s[i]);
      sb.push_back(s[i].e);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL counter[%0d] got=%h exp=%h", i, obs(), e); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_alias();
    step_t s[$];
    logic [40:0] e;
    do_reset();
    s.push_back(mk(32'h220, 1, 32'h120, 1, 32'h200, 0, 32'h124, 0, ex(0, 0, 32'h224, 1, 0, 0)));
    s.push_back(mk(32'h220, 1, 32'h220, 1, 32'h300, 0, 32'h224, 0, ex(0, 0, 32'h224, 1, 1, 1)));
    s.push_back(mk(32'h120, 0, 32'h120, 0, 0, 0, 32'hDEAD, 0, ex(0, 0, 32'h124, 0, 2, 2)));
    s.push_back(mk(32'h220, 0, 0, 0, 0, 0, 0, 0, ex(1, 1, 32'h300, 0, 2, 2)));
    foreach (s[i]) begin
      apply(s[i]);
      sb.push_back(s[i].e);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL alias[%0d] got=%h exp=%h", i, obs(), e); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_flush();
    step_t s[$];
    logic [40:0] e;
    s.push_back(mk(32'h220, 1, 32'h120, 1, 32'h500, 0, 32'h124, 1, ex(1, 1, 32'h300, 1, 2, 2)));
    s.push_back(mk(32'h220, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 32'h224, 0, 3, 3)));
    s.push_back(mk(32'h120, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 32'h124, 0, 3, 3)));
    foreach (s[i]) begin
      apply(s[i]);
      sb.push_back(s[i].e);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL flush[%0d] got=%h exp=%h", i, obs(), e); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset_mid_update();
    logic [40:0] e;
    apply(mk(32'h120, 1, 32'h120, 1, 32'h200, 0, 32'h124, 0, 0));
    sb.push_back(ex(0, 0, 32'h124, 1, 3, 3));
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL mid_alloc got=%h exp=%h", obs(), e); end
    @(posedge clk); #1;
    sb.push_back(ex(1, 1, 32'h200, 1, 4, 4));
    #1;
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL mid_before got=%h exp=%h", obs(), e); end
    reset = 1;
    sb.push_back(ex(0, 0, 32'h124, 1, 0, 0));
    #1;
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL mid_async got=%h exp=%h", obs(), e); end
    @(posedge clk); #1;
    reset = 0; upd_valid_EX = 0;
    sb.push_back(ex(0, 0, 32'h124, 0, 0, 0));
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL mid_after got=%h exp=%h", obs(), e); end
    @(posedge clk); #1;
  endtask
  task automatic test_saturation();
    step_t s[$];
    logic [40:0] e;
    do_reset();
    for (int k = 0; k < 9; k++)
      s.push_back(mk(32'hFFFFFFFC, 1, 32'h400, 0, 0, 1, 32'h999, 0,
                     ex(0, 0, 32'h0, 1, 3'(k > 7 ? 7 : k), 3'(k > 7 ? 7 : k))));
    s.push_back(mk(32'hFFFFFFFC, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 32'h0, 0, 7, 7)));
    foreach (s[i]) begin
      apply(s[i]);
      sb.push_back(s[i].e);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL saturation[%0d] got=%h exp=%h", i, obs(), e); end
      @(posedge clk); #1;
    end
  endtask
  initial begin
    test_reset();
    test_counter();
    test_alias();
    test_flush();
    test_reset_mid_update();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bpred_btb.md
Name: bpred_btb

Overview:
Parameterised branch target buffer with per-entry saturating direction counters.
- Replaces the fixed pc+4 next-PC computation in the fetch stage of the pipelined core.
- FE does a combinational lookup on the current PC; EX sends resolved branch/JAL outcomes back for training.
- Also keeps saturating statistics counters for resolved control transfers and mispredictions.

Parameters:
- DBITS, 32, PC/target width.
- INDEXBITS, 6, log2 of entry count (64 entries).
- CTRBITS, 2, width of each direction counter (≥1).
- STATBITS, 16, width of each statistics counter.
- INSTSIZE, 4, PC increment; PCs are word-aligned and bits [1:0] are ignored.

Ports:
- clk, input, 1, sole clock.
- reset, input, 1, asynchronous active-high reset.
- flush, input, 1, synchronous invalidate of all entries.
- pc_FE, input, DBITS, fetch PC to look up.
- hit_FE, output, 1, valid entry with matching tag.
- predtaken_FE, output, 1, predicted taken.
- pcpred_FE, output, DBITS, predicted next PC.
- upd_valid_EX, input, 1, a control transfer resolved this cycle.
- upd_pc_EX, input, DBITS, PC of the resolved instruction.
- upd_taken_EX, input, 1, actual direction.
- upd_target_EX, input, DBITS, actual target.
- upd_predtaken_EX, input, 1, prediction made for it in FE.
- upd_predpc_EX, input, DBITS, next PC predicted for it in FE.
- mispred_EX, output, 1, combinational; upd_valid_EX and the prediction was wrong.
- stat_ctrl, output, STATBITS, resolved control-transfer count.
- stat_mispred, output, STATBITS, misprediction count.

Behaviour:
- Address split:
  - idx = pc[INDEXBITS+1:2]
  - tag = pc[DBITS-1:INDEXBITS+2]
- Entry contents: valid, tag, target[DBITS], ctr[CTRBITS].
- Lookup (combinational, zero latency):
  - hit_FE = valid[idx] && tag match.
  - predtaken_FE = hit_FE && ctr[CTRBITS-1].
  - pcpred_FE = predtaken_FE ? target : pc_FE + INSTSIZE (modulo 2^DBITS; wrap-around is allowed).
- Correct next PC: upd_taken_EX ? upd_target_EX : upd_pc_EX + INSTSIZE.
- mispred_EX = upd_valid_EX && (upd_predpc_EX != correct next PC). It is 0 whenever upd_valid_EX = 0.
- Update on posedge when upd_valid_EX = 1 and flush = 0:
  - Hit at upd idx:
    - ctr increments on taken, decrements on not-taken, saturating at all-ones and zero.
    - target is overwritten with upd_target_EX only when taken.
  - Miss and taken: allocate (overwrite any occupant). Set valid = 1, tag, target = upd_target_EX, ctr = weakly taken (1 followed by CTRBITS-1 zeros).
  - Miss and not-taken: table unchanged.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update contents. The new state is visible from the next cycle. There is no write-through.
- Statistics:
  - stat_ctrl increments on every upd_valid_EX.
  - stat_mispred increments when mispred_EX = 1.
  - Both saturate at 2^STATBITS-1 and never wrap.
  - Both keep counting during flush.
- flush:
  - Clears all valid bits at the next posedge.
  - flush has priority over a simultaneous update; that update is dropped from the table but still counted in the statistics.
  - Lookups in the flush cycle still use the old contents.
- Reset (asynchronous, any time including mid-update):
  - All valid = 0.
  - All ctr = weakly not-taken (0 followed by CTRBITS-1 ones).
  - Statistics = 0.
  - Outputs immediately: hit_FE = 0, predtaken_FE = 0, pcpred_FE = pc_FE + INSTSIZE; mispred_EX follows its inputs.
  - An update in progress is lost.
- Targets and tags need not be reset; only the valid and ctr arrays do.

Decomposition:
- Shared package holds DBITS, INSTSIZE, and the weak-taken / weak-not-taken counter encodings, as functions of CTRBITS.
- One natural sub-module, sat_counter: a parameterised width, inc/dec, saturating counter.
  - Reused for the per-entry direction logic.
  - Reused for both statistics counters, in increment-only mode.

Test Plan:
- Reset, then pc_FE = 0x100 -> hit_FE = 0, predtaken_FE = 0, pcpred_FE = 0x104; stat_ctrl = stat_mispred = 0.
- Update pc = 0x120 taken target 0x200, predpc 0x124 -> mispred_EX = 1 that cycle. Next cycle lookup 0x120 gives hit = 1, predtaken = 1, pcpred = 0x200. stat_ctrl = 1, stat_mispred = 1.
- Same entry: two not-taken updates (predpc 0x200, then 0x124):
  - The first yields mispred_EX = 1 and ctr 10 -> 01, so lookup 0x120 then gives pcpred 0x124.
  - The second yields mispred_EX = 0 and ctr 01 -> 00.
  - Three taken updates then give ctr 01, 10, 11; a further taken update keeps it saturated at 11.
- Alias: with CTRBITS = 2 and INDEXBITS = 6, 0x120 is allocated; then update 0x220 (same idx, different tag) taken target 0x300. Lookup 0x120 gives hit = 0 and pcpred 0x124; lookup 0x220 gives pcpred 0x300.
- flush and update on the same cycle -> all lookups miss next cycle, and stat_ctrl still increments. Also assert reset while upd_valid_EX = 1 -> lookup misses and stats = 0 after release.
- Saturation: STATBITS = 3, 9 consecutive mispredicting updates -> stat_ctrl = stat_mispred = 7, not 1. Also lookup 0xFFFFFFFC on a miss -> pcpred_FE = 0x00000000.
